countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 136 +++++++++++++
 tb/tb_countdown_timer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer with run/pause control and optional auto-reload on expiry.
// All outputs come straight from registers; running/expired are decodes of the state register.
`timescale 1ns/1ps
module countdown_timer #(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       load,
  input  logic       start_pause,
  input  logic [3:0] preset_min_tens,
  input  logic [3:0] preset_min_ones,
  input  logic [3:0] preset_sec_tens,
  input  logic [3:0] preset_sec_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       expired,
  output logic       done_pulse
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [15:0] rld, rld_n;
  logic        done_n;
  logic [15:0] dec;
  logic [15:0] clamped;

  function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  always_comb begin
    clamped = {clamp(preset_min_tens, 4'd9), clamp(preset_min_ones, 4'd9),
               clamp(preset_sec_tens, 4'd5), clamp(preset_sec_ones, 4'd9)};
  end

  // BCD decrement by one second with borrow chain sec_ones -> sec_tens -> min_ones -> min_tens
  always_comb begin
    dec = cnt;
    if (cnt[3:0] == 4'd0) begin
      dec[3:0] = 4'd9;
      if (cnt[7:4] == 4'd0) begin
        dec[7:4] = 4'd5;
        if (cnt[11:8] == 4'd0) begin
          dec[11:8]  = 4'd9;
          dec[15:12] = cnt[15:12] - 4'd1;
        end else begin
          dec[11:8] = cnt[11:8] - 4'd1;
        end
      end else begin
        dec[7:4] = cnt[7:4] - 4'd1;
      end
    end else begin
      dec[3:0] = cnt[3:0] - 4'd1;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rld_n   = rld;
    done_n  = 1'b0;
    if (load) begin
      cnt_n   = clamped;
      rld_n   = clamped;
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_pause && (cnt != '0)) state_n = RUNNING;
        end
        RUNNING: begin
          if (start_pause) begin
            state_n = PAUSED;
          end else if (tick) begin
            // a zero count here is treated as expiry so the borrow chain never underflows
            if ((cnt == '0) || (cnt == 16'h0001)) begin
              done_n = 1'b1;
              if (AUTO_RELOAD && (rld != '0)) begin
                cnt_n = rld;
              end else begin
                cnt_n   = '0;
                state_n = EXPIRED;
              end
            end else begin
              cnt_n = dec;
            end
          end
        end
        PAUSED: begin
          if (start_pause) state_n = RUNNING;
        end
        EXPIRED: begin
          if (start_pause) begin
            state_n = IDLE;
            cnt_n   = rld;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      rld        <= '0;
      done_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      rld        <= rld_n;
      done_pulse <= done_n;
    end
  end

  assign min_tens = cnt[15:12];
  assign min_ones = cnt[11:8];
  assign sec_tens = cnt[7:4];
  assign sec_ones = cnt[3:0];
  assign running  = (state == RUNNING);
  assign expired  = (state == EXPIRED);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: a stop-at-zero instance and an auto-reload instance share stimulus.
`timescale 1ns/1ps
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0, load = 1'b0, sp = 1'b0;
  logic [15:0] preset = '0;

  logic [3:0] mt0, mo0, st0, so0, mt1, mo1, st1, so1;
  logic       run0, exp0, done0, run1, exp1, done1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  countdown_timer #(.AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .load(load), .start_pause(sp),
    .preset_min_tens(preset[15:12]), .preset_min_ones(preset[11:8]),
    .preset_sec_tens(preset[7:4]),   .preset_sec_ones(preset[3:0]),
    .min_tens(mt0), .min_ones(mo0), .sec_tens(st0), .sec_ones(so0),
    .running(run0), .expired(exp0), .done_pulse(done0)
  );

  countdown_timer #(.AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .load(load), .start_pause(sp),
    .preset_min_tens(preset[15:12]), .preset_min_ones(preset[11:8]),
    .preset_sec_tens(preset[7:4]),   .preset_sec_ones(preset[3:0]),
    .min_tens(mt1), .min_ones(mo1), .sec_tens(st1), .sec_ones(so1),
    .running(run1), .expired(exp1), .done_pulse(done1)
  );

  typedef struct {
    logic        ld, s, t;
    logic [15:0] p;
    logic [15:0] cnt;
    logic [2:0]  flags;  // {running, expired, done_pulse}
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(input logic ld, input logic s, input logic t,
                              input logic [15:0] p, input logic [15:0] cnt,
                              input logic [2:0] flags);
    vec_t v;
    v.ld = ld; v.s = s; v.t = t; v.p = p; v.cnt = cnt; v.flags = flags;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic l, input logic s, input logic t, input logic [15:0] p);
    load = l; sp = s; tick = t; preset = p;
    @(posedge clk);
    #1;
    load = 1'b0; sp = 1'b0; tick = 1'b0; preset = '0;
  endtask

  int unsigned pulses;

  initial begin
    vecs[0]  = mk(0, 0, 0, 16'h0000, 16'h0000, 3'b000);
    vecs[1]  = mk(0, 1, 0, 16'h0000, 16'h0000, 3'b000);  // start ignored at 00:00
    vecs[2]  = mk(1, 0, 0, 16'h0100, 16'h0100, 3'b000);
    vecs[3]  = mk(0, 0, 1, 16'h0000, 16'h0100, 3'b000);  // tick in IDLE ignored
    vecs[4]  = mk(0, 1, 0, 16'h0000, 16'h0100, 3'b100);
    vecs[5]  = mk(0, 0, 1, 16'h0000, 16'h0059, 3'b100);
    vecs[6]  = mk(1, 0, 0, 16'h0002, 16'h0002, 3'b000);
    vecs[7]  = mk(0, 1, 0, 16'h0000, 16'h0002, 3'b100);
    vecs[8]  = mk(0, 0, 1, 16'h0000, 16'h0001, 3'b100);
    vecs[9]  = mk(0, 0, 1, 16'h0000, 16'h0000, 3'b011);
    vecs[10] = mk(0, 0, 0, 16'h0000, 16'h0000, 3'b010);
    vecs[11] = mk(0, 0, 1, 16'h0000, 16'h0000, 3'b010);
    vecs[12] = mk(0, 1, 0, 16'h0000, 16'h0002, 3'b000);  // EXPIRED -> IDLE with reload
    vecs[13] = mk(1, 0, 0, 16'h1000, 16'h1000, 3'b000);
    vecs[14] = mk(0, 1, 0, 16'h0000, 16'h1000, 3'b100);
    vecs[15] = mk(0, 0, 1, 16'h0000, 16'h0959, 3'b100);
    vecs[16] = mk(0, 0, 1, 16'h0000, 16'h0958, 3'b100);
    vecs[17] = mk(0, 0, 1, 16'h0000, 16'h0957, 3'b100);
    vecs[18] = mk(0, 0, 1, 16'h0000, 16'h0956, 3'b100);
    vecs[19] = mk(0, 0, 1, 16'h0000, 16'h0955, 3'b100);
    vecs[20] = mk(0, 0, 1, 16'h0000, 16'h0954, 3'b100);
    vecs[21] = mk(0, 1, 1, 16'h0000, 16'h0954, 3'b000);  // pause wins over tick
    vecs[22] = mk(0, 0, 1, 16'h0000, 16'h0954, 3'b000);
    vecs[23] = mk(0, 1, 0, 16'h0000, 16'h0954, 3'b100);
    vecs[24] = mk(1, 1, 1, 16'h9F7C, 16'h9959, 3'b000);  // load wins; digits clamped
    vecs[25] = mk(0, 0, 1, 16'h0000, 16'h9959, 3'b000);

    #2;
    check("reset_cnt0", {mt0, mo0, st0, so0}, 16'h0000);
    check("reset_flags0", {13'd0, run0, exp0, done0}, 16'h0000);
    check("reset_cnt1", {mt1, mo1, st1, so1}, 16'h0000);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 26; i++) begin
      step(vecs[i].ld, vecs[i].s, vecs[i].t, vecs[i].p);
      check($sformatf("vec%0d_cnt", i), {mt0, mo0, st0, so0}, vecs[i].cnt);
      check($sformatf("vec%0d_flags", i), {13'd0, run0, exp0, done0}, {13'd0, vecs[i].flags});
    end

    // Auto-reload: 00:03 counts down and wraps back to 00:03 with one done pulse
    pulses = 0;
    step(1, 0, 0, 16'h0003);
    check("ar_load", {mt1, mo1, st1, so1}, 16'h0003);
    step(0, 1, 0, 16'h0000);
    pulses += int'(done1);
    step(0, 0, 1, 16'h0000);
    pulses += int'(done1);
    check("ar_t1", {mt1, mo1, st1, so1}, 16'h0002);
    step(0, 0, 1, 16'h0000);
    pulses += int'(done1);
    step(0, 0, 1, 16'h0000);
    pulses += int'(done1);
    check("ar_t3_cnt", {mt1, mo1, st1, so1}, 16'h0003);
    check("ar_t3_flags", {13'd0, run1, exp1, done1}, 16'h0005);
    check("noar_t3_flags", {13'd0, run0, exp0, done0}, 16'h0003);
    check("noar_t3_cnt", {mt0, mo0, st0, so0}, 16'h0000);
    step(0, 0, 0, 16'h0000);
    pulses += int'(done1);
    check("ar_after_flags", {13'd0, run1, exp1, done1}, 16'h0004);
    check("ar_pulse_count", 16'(pulses), 16'd1);

    // Asynchronous reset mid-run at 05:17
    step(1, 0, 0, 16'h0517);
    step(0, 1, 0, 16'h0000);
    check("rst_pre_cnt", {mt0, mo0, st0, so0}, 16'h0517);
    step(0, 0, 1, 16'h0000);
    check("rst_pre_tick", {mt0, mo0, st0, so0}, 16'h0516);
    #3 rst_n = 1'b0;
    #1;
    check("rst_async_cnt", {mt0, mo0, st0, so0}, 16'h0000);
    check("rst_async_flags", {13'd0, run0, exp0, done0}, 16'h0000);
    check("rst_async_flags1", {13'd0, run1, exp1, done1}, 16'h0000);
    rst_n = 1'b1;
    step(0, 1, 0, 16'h0000);
    check("rst_sp_cnt", {mt0, mo0, st0, so0}, 16'h0000);
    check("rst_sp_flags", {13'd0, run0, exp0, done0}, 16'h0000);
    step(0, 0, 1, 16'h0000);
    check("rst_tick_flags", {13'd0, run0, exp0, done0}, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
